chunked_serial_adder: RTL and testbench

- Multi-cycle adder/subtractor for WIDTH-bit operands, processing CHUNK bits per clock with a registered carry between chunks.
- Successor to the single-bit combinational adder cell: it adds width, add/sub mode, carry-in, carry-out, signed overflow, and valid/ready handshakes on both sides.
- Serves as a small, area-cheap arithmetic datapath element, placed between a producer and a consumer that both follow the handshake.

---
 rtl/chunked_serial_adder.sv | 143 ++++++++++++++
 tb/tb_chunked_serial_adder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
// Multi-cycle adder/subtractor for WIDTH-bit operands. Each CALC cycle adds one
// CHUNK-bit slice (LSB slice first) and keeps the carry in a register between
// slices. Operands and results use valid/ready handshakes. Only one operation
// is in flight at a time.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if ((WIDTH < 1) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] b_eff;

    // Slice adder and the result register with the new slice shifted in at the top
    always_comb begin
        chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        res_shift = (res_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        b_eff     = sub ? ~b : b;
    end

    // Handshake FSM and datapath next-state
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = sub | cin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                end
            end
            CALC: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                res_d   = res_shift;
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    sum_d   = res_shift;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Testbench for chunked_serial_adder: directed table and corner sequences on
// the 16/4 configuration, random transactions on 16/1, 16/16 and 8/2, all
// checked through a per-instance scoreboard queue.
`timescale 1ns/1ps
module tb_chunked_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit done [4];

    // Edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W = (g == 3) ? 8 : 16;
        localparam int C = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 2;
        localparam int N = W / C;
        localparam int T = 1000;

        typedef struct packed {
            logic [W-1:0] s;
            logic         c;
            logic         o;
        } res_t;

        logic         rst_n, in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
        logic [W-1:0] a, b, sum;
        res_t         cur_exp;
        res_t         exp_q [$];
        res_t         held;
        res_t         e;
        int           acc_edge = 0;
        int           n_done   = 0;
        logic         ov_prev  = 1'b0;
        logic         or_prev  = 1'b0;

        chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .sub       (sub),
            .cin       (cin),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf)
        );

        // Reference: whole-width unsigned and signed arithmetic
        function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s, input logic ci);
            res_t            r;
            longint          sx, sy, sr, lo, hi;
            longint unsigned ux, uy, ur;
            ux = 64'(x);
            uy = 64'(y);
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            lo = -(longint'(1) << (W - 1));
            hi = (longint'(1) << (W - 1)) - 1;
            if (s) begin
                ur  = ux - uy;
                r.c = (ux >= uy);
                sr  = sx - sy;
            end else begin
                ur  = ux + uy + 64'(ci);
                r.c = ur[W];
                sr  = sx + sy + longint'(ci);
            end
            r.s = ur[W-1:0];
            r.o = (sr < lo) || (sr > hi);
            return r;
        endfunction

        // Scoreboard monitor, sampled on the falling edge
        initial begin
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    exp_q.delete();
                    ov_prev = 1'b0;
                    or_prev = 1'b0;
                end else begin
                    if (out_valid && !ov_prev)
                        check($sformatf("cfg%0d latency", g), 32'(cyc - acc_edge), N);
                    if (out_valid && ov_prev && !or_prev)
                        check($sformatf("cfg%0d hold", g), 32'({sum, cout, ovf}), 32'(held));
                    if (out_valid && out_ready) begin
                        check($sformatf("cfg%0d result present", g), 32'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check($sformatf("cfg%0d sum", g), 32'(sum), 32'(e.s));
                            check($sformatf("cfg%0d cout", g), 32'(cout), 32'(e.c));
                            check($sformatf("cfg%0d ovf", g), 32'(ovf), 32'(e.o));
                        end
                        n_done++;
                    end
                    if (in_valid && in_ready) begin
                        exp_q.push_back(cur_exp);
                        acc_edge = cyc + 1;
                    end
                    ov_prev = out_valid;
                    or_prev = out_ready;
                    held    = {sum, cout, ovf};
                end
            end
        end

        if (g == 0) begin : g_dir
            typedef struct {
                logic [W-1:0] va, vb;
                logic         vs, vc;
                logic [W-1:0] es;
                logic         ec, eo;
            } vec_t;
            vec_t vt [9];

            task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic ts, input logic tc, input res_t te);
                a = ta; b = tb; sub = ts; cin = tc; cur_exp = te;
                in_valid = 1'b1;
            endtask

            task automatic wait_accept(input string tag);
                int k = 0;
                while (!in_ready && k < 50) begin
                    @(posedge clk); #1;
                    k++;
                end
                check({tag, " in_ready before accept"}, 32'(in_ready), 1);
                @(posedge clk); #1;
                in_valid = 1'b0;
            endtask

            task automatic wait_result(input string tag);
                int k = 0;
                while (!out_valid && k < 50) begin
                    @(posedge clk); #1;
                    k++;
                end
                check({tag, " out_valid"}, 32'(out_valid), 1);
            endtask

            initial begin
                int   lat;
                logic seen;
                vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
                vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
                vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
                vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
                vt[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
                vt[5] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
                vt[6] = '{16'h0007, 16'h0007, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
                vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
                vt[8] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};

                rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
                a = '0; b = '0; sub = 1'b0; cin = 1'b0; cur_exp = '0;
                @(posedge clk); #1;
                in_valid = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                check("reset in_ready", 32'(in_ready), 1);
                check("reset out_valid", 32'(out_valid), 0);
                check("reset sum", 32'(sum), 0);
                check("reset cout/ovf", 32'({cout, ovf}), 0);
                in_valid = 1'b0;
                rst_n    = 1'b1;
                @(posedge clk); #1;
                check("post-reset in_ready", 32'(in_ready), 1);

                for (int i = 0; i < 9; i++) begin
                    drive(vt[i].va, vt[i].vb, vt[i].vs, vt[i].vc, '{vt[i].es, vt[i].ec, vt[i].eo});
                    wait_accept($sformatf("vec%0d", i));
                    lat = 0;
                    while (!out_valid && lat < 40) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    check($sformatf("vec%0d edges to out_valid", i), 32'(lat), N);
                    check($sformatf("vec%0d in_ready in DONE", i), 32'(in_ready), 0);
                    check($sformatf("vec%0d sum", i), 32'(sum), 32'(vt[i].es));
                    check($sformatf("vec%0d cout", i), 32'(cout), 32'(vt[i].ec));
                    check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vt[i].eo));
                    @(posedge clk); #1;
                    check($sformatf("vec%0d back to idle", i), 32'({in_ready, out_valid}), 32'(2'b10));
                end
                @(posedge clk); #1;
                check("idle keeps last sum", 32'(sum), 32'(vt[8].es));

                // Backpressure with new operands waiting
                out_ready = 1'b0;
                drive(16'h00AA, 16'h0055, 1'b0, 1'b0, '{16'h00FF, 1'b0, 1'b0});
                wait_accept("bp first");
                wait_result("bp first");
                drive(16'h0100, 16'h0200, 1'b0, 1'b0, '{16'h0300, 1'b0, 1'b0});
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk); #1;
                    check($sformatf("bp stall%0d out_valid", i), 32'(out_valid), 1);
                    check($sformatf("bp stall%0d in_ready", i), 32'(in_ready), 0);
                    check($sformatf("bp stall%0d sum", i), 32'(sum), 32'h00FF);
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                check("bp consumed idle", 32'({in_ready, out_valid}), 32'(2'b10));
                @(posedge clk); #1;
                check("bp second accepted", 32'(in_ready), 0);
                in_valid = 1'b0;
                wait_result("bp second");
                check("bp second sum", 32'(sum), 32'h0300);
                @(posedge clk); #1;

                // Reset while the third slice is being computed
                drive(16'h1111, 16'h2222, 1'b0, 1'b0, '{16'h3333, 1'b0, 1'b0});
                wait_accept("abort");
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check("abort in_ready", 32'(in_ready), 1);
                check("abort out_valid", 32'(out_valid), 0);
                check("abort sum", 32'(sum), 0);
                check("abort cout/ovf", 32'({cout, ovf}), 0);
                seen = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk); #1;
                    seen = seen | out_valid;
                end
                check("abort no output", 32'(seen), 0);
                drive(16'h0003, 16'h0004, 1'b0, 1'b0, '{16'h0007, 1'b0, 1'b0});
                wait_accept("after abort");
                wait_result("after abort");
                check("after abort sum", 32'(sum), 32'h0007);
                @(posedge clk); #1;
                @(posedge clk); #1;
                check("directed queue drained", 32'(exp_q.size()), 0);
                done[g] = 1'b1;
            end
        end else begin : g_rnd
            // Random consumer backpressure
            initial begin
                out_ready = 1'b0;
                forever begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end

            initial begin
                int k;
                rst_n = 1'b0; in_valid = 1'b0;
                a = '0; b = '0; sub = 1'b0; cin = 1'b0; cur_exp = '0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                for (int t = 0; t < T; t++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    a   = W'($urandom);
                    b   = W'($urandom);
                    sub = 1'($urandom_range(0, 1));
                    cin = 1'($urandom_range(0, 1));
                    cur_exp  = model(a, b, sub, cin);
                    in_valid = 1'b1;
                    k = 0;
                    while (!in_ready && k < 300) begin
                        @(posedge clk); #1;
                        k++;
                    end
                    if (!in_ready) begin
                        check($sformatf("cfg%0d accept timeout", g), 32'(in_ready), 1);
                        break;
                    end
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
                k = 0;
                while (n_done < T && k < 2000) begin
                    @(posedge clk); #1;
                    k++;
                end
                check($sformatf("cfg%0d results seen", g), 32'(n_done), T);
                done[g] = 1'b1;
            end
        end
    end

    initial begin
        int k = 0;
        while (!(done[0] && done[1] && done[2] && done[3]) && k < 90000) begin
            @(posedge clk);
            k++;
        end
        if (!(done[0] && done[1] && done[2] && done[3])) begin
            checks++;
            errors++;
            $display("FAIL run timeout: done=%b%b%b%b want 1111", done[3], done[2], done[1], done[0]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
